// File: rtl/omux_arbiter.sv
// Round-robin arbiter sharing the host TX byte path between N FWFT byte sources.
// Grants are burst-limited to MAX_BURST bytes and separated by at least one idle cycle.
module omux_arbiter #(
  parameter int N         = 4,
  parameter int SELW      = 2,
  parameter int MAX_BURST = 64
) (
  input  logic              clk_i,
  input  logic              nreset_i,
  input  logic [N-1:0]      req_i,
  input  logic [8*N-1:0]    data_i,
  output logic [N-1:0]      ack_o,
  input  logic [N-1:0]      enable_i,
  input  logic              tx_ready_i,
  output logic              tx_valid_o,
  output logic [7:0]        tx_data_o,
  output logic [SELW-1:0]   sel_o,
  output logic              busy_o,
  output logic [7:0]        grant_count_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] last_q, last_d;
  logic [7:0]      count_q, count_d;
  logic            busy_q, busy_d;

  logic [N-1:0]    elig;
  logic [SELW-1:0] winner;
  logic            found;
  logic            sel_elig;
  logic            xfer;
  logic            burst_end;

  assign elig = req_i & enable_i;

  // Cyclic search starting just after the previous owner, so it ends up lowest priority.
  always_comb begin : rr_search
    logic [5:0] cand;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = 6'(last_q) + 6'(k);
      if (cand >= 6'(N)) cand = cand - 6'(N);
      if (!found && elig[cand[SELW-1:0]]) begin
        found  = 1'b1;
        winner = cand[SELW-1:0];
      end
    end
  end

  assign sel_elig   = elig[sel_q];
  assign tx_valid_o = (state_q == GRANT) && sel_elig;
  assign tx_data_o  = data_i[8*sel_q +: 8];
  assign xfer       = tx_valid_o && tx_ready_i;
  assign burst_end  = xfer && (count_q == 8'(MAX_BURST - 1));

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ack
      assign ack_o[gi] = xfer && (sel_q == SELW'(gi));
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    count_d = count_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = winner;
          last_d  = winner;
          count_d = 8'd0;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (xfer) count_d = count_q + 8'd1;
        // Dropped request or enable shows up as sel_elig low.
        if (!sel_elig || burst_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SELW'(N - 1);
      count_q <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign sel_o         = sel_q;
  assign busy_o        = busy_q;
  assign grant_count_o = count_q;

endmodule

// File: doc/omux_arbiter.md
Name: omux_arbiter

Overview:
- Round-robin arbiter that shares the host interface TX byte path between N byte-stream sources: timestamp streams, status, and similar.
- Sits between the sources and the host interface output mux. Drives the mux select, forwards the granted source's byte to the host interface, and returns per-source pop strobes.
- Bounds burst length so no source starves the others. Sources can be masked individually from a configuration register.

Parameters:
- N, 4, number of requesting sources (2..16)
- SELW, 2, width of select output; must satisfy 2**SELW >= N
- MAX_BURST, 64, maximum bytes transferred per grant before forced re-arbitration (1..255)

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- nreset_i  in  1  asynchronous active-low reset
- req_i  in  N  source k has a byte available on data_i[8k+7:8k] (first-word-fall-through)
- data_i  in  8*N  concatenated source bytes
- ack_o  out  N  one-cycle pop strobe to the granted source when its byte is taken
- enable_i  in  N  per-source enable mask from a register; disabled sources are never granted
- tx_ready_i  in  1  host interface can accept a byte this cycle
- tx_valid_o  out  1  tx_data_o holds a valid byte
- tx_data_o  out  8  byte forwarded to the host interface
- sel_o  out  SELW  index of the currently or last granted source (host interface omux select)
- busy_o  out  1  a grant is active
- grant_count_o  out  8  bytes transferred in the current grant

Behaviour:
- Reset (nreset_i low, asynchronous): state IDLE; sel_o=0; busy_o=0; grant_count_o=0; rr pointer last=N-1, so source 0 has first priority. tx_valid_o=0 and ack_o=0 follow combinationally from IDLE.
- Eligible vector: elig = req_i & enable_i.
- State IDLE:
  - If elig != 0, choose the first set bit searching cyclically from last+1.
  - On the next edge: sel_o<=winner, last<=winner, grant_count_o<=0, busy_o<=1, go GRANT.
  - If elig == 0, remain in IDLE.
- State GRANT:
  - tx_valid_o = req_i[sel_o] & enable_i[sel_o] (combinational).
  - tx_data_o = data_i[8*sel_o +: 8] (combinational).
  - Transfer occurs in any cycle with tx_valid_o & tx_ready_i. In that cycle ack_o[sel_o]=1 and all other ack bits are 0. grant_count_o increments on the edge.
  - Release (go IDLE on next edge, busy_o<=0) when any of the following holds:
    - (a) req_i[sel_o]=0;
    - (b) enable_i[sel_o]=0;
    - (c) a transfer occurs with grant_count_o == MAX_BURST-1.
  - If tx_ready_i=0 with the source still requesting, hold GRANT indefinitely. No timeout applies.
- Minimum one IDLE cycle between grants. After a grant ends, the previous owner has lowest priority.
- ack_o is never asserted outside GRANT. At most one ack bit is high per cycle.
- sel_o holds its value in IDLE; it changes only on a new grant.
- grant_count_o width is 8 bits and never exceeds MAX_BURST.
- A source disabled mid-grant releases immediately; no transfer occurs in that cycle because tx_valid_o is low.
- Simultaneous requests: lowest index cyclically after last wins.
- If a source drops req_i in the same cycle as a transfer attempt, no transfer occurs (tx_valid_o low) and the block releases.
- Reset asserted mid-grant: outputs return to reset values immediately. The pending byte is not acked.
- Non-power-of-two N: indices >= N are never selected.

Test Plan:
1. After reset, enable_i=4'hF, req_i=4'b0001, data0=8'h55, tx_ready_i=1 → GRANT one cycle later, sel_o=0, tx_data_o=8'h55, ack_o=4'b0001 each cycle while req held; busy_o drops one cycle after req_i[0] falls.
2. req_i=4'b1111 held constantly, MAX_BURST=4, tx_ready_i=1 → grant order 0,1,2,3,0. Each grant exactly 4 acks, followed by one idle cycle; grant_count_o reaches 3 before release.
3. Source 1 granted, tx_ready_i=0 for 10 cycles → tx_valid_o=1 and ack_o=0 throughout; no re-arbitration. First ack on the cycle tx_ready_i returns high.
4. enable_i=4'b1011, req_i=4'b0100 → never granted, busy_o=0. Set enable_i[2]=1 → grant to source 2. Clear enable_i[2] mid-grant → tx_valid_o=0 that cycle and release next edge.
5. Requests on sources 1 and 3 after source 1 was the last owner → source 3 wins, then source 1.
6. Pull nreset_i low during GRANT with transfers active → sel_o=0, busy_o=0, tx_valid_o=0 and ack_o=0 immediately. After release with req_i=4'b0001, source 0 is granted first.
